// File: rtl/johnson_sequencer_if.sv
// Command/status bundle between a controlling FSM and johnson_sequencer.
// With JSEQ_LOAD_EN defined the bundle also carries load / load_val.
interface johnson_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] steps;
    logic             dir;
    logic             hold;
    logic             stop;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             wrap;
    logic             err;
`ifdef JSEQ_LOAD_EN
    logic             load;
    logic [WIDTH-1:0] load_val;
`endif

    modport master (
        output start, steps, dir, hold, stop,
`ifdef JSEQ_LOAD_EN
        output load, load_val,
`endif
        input  out, busy, done, aborted, wrap, err
    );

    modport slave (
        input  start, steps, dir, hold, stop,
`ifdef JSEQ_LOAD_EN
        input  load, load_val,
`endif
        output out, busy, done, aborted, wrap, err
    );
endinterface

// File: rtl/johnson_sequencer.sv
// Run-controlled Johnson counter: steps a WIDTH-stage register a programmed
// count in either direction. Define JSEQ_LOAD_EN to add the IDLE-time preload.
module johnson_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    johnson_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] remaining_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             wrap_q;
    logic             err_q;

    logic [WIDTH-1:0] fwd_d;
    logic [WIDTH-1:0] rev_d;
    logic [WIDTH-1:0] out_d;

    // Forward shifts toward the MSB feeding ~MSB in; reverse is its exact inverse.
    assign fwd_d[0]       = ~out_q[WIDTH-1];
    assign rev_d[WIDTH-1] = ~out_q[0];
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign fwd_d[gi]   = out_q[gi-1];
            assign rev_d[gi-1] = out_q[gi];
        end
    endgenerate

    assign out_d = dir_q ? rev_d : fwd_d;

`ifdef JSEQ_LOAD_EN
    // Legal codes: zero, a run of 1s from the LSB, or a run of 1s from the MSB.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] inv;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        inv = ~v;
        return ((v & (v + one)) == '0) || ((inv & (inv + one)) == '0);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef JSEQ_LOAD_EN
                    if (bus.load) begin
                        if (is_legal(bus.load_val)) begin
                            out_q <= bus.load_val;
                        end else begin
                            out_q <= '0;
                            err_q <= 1'b1;
                        end
                    end else
`endif
                    if (bus.start) begin
                        if (bus.steps != '0) begin
                            state_q     <= RUN;
                            busy_q      <= 1'b1;
                            remaining_q <= bus.steps;
                            dir_q       <= bus.dir;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (!bus.hold) begin
                        out_q       <= out_d;
                        wrap_q      <= (out_d == '0);
                        remaining_q <= remaining_q - CNT_ONE;
                        if (remaining_q == CNT_ONE) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.wrap    = wrap_q;
`ifdef JSEQ_LOAD_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif
endmodule

// File: doc/johnson_sequencer.md
# johnson_sequencer

- Run-controlled Johnson counter with a start/done handshake.
- Owns a WIDTH-stage Johnson register and advances it a programmed number of steps, in either direction, on command.
- Supports hold, abort and wrap reporting.
- Sits between a test/control FSM and any logic consuming the Johnson phase outputs; it replaces the free-running counter wherever stepping must be scheduled.

## Interface
Parameters:
- WIDTH, 4, Johnson stages (2*WIDTH legal states)
- CNT_W, 8, width of step count

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- steps  in  CNT_W  number of steps for the run; latched with start
- dir  in  1  0 = forward, 1 = reverse; latched with start
- hold  in  1  freeze stepping while high (RUN only)
- stop  in  1  abort the current run (RUN only)
- out  out  WIDTH  Johnson register
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on stop
- wrap  out  1  one-cycle pulse when a step lands on all-zero
- err  out  1  sticky illegal-load flag (see Configuration)

## Operation
- States: IDLE, RUN, FINISH.
- Reset: state IDLE; all outputs 0 (out=0, busy, done, aborted, wrap, err).
- rst has priority over everything, including mid-run. It aborts without asserting done or aborted.
- IDLE:
  - start=1, steps!=0 → RUN; latch remaining=steps and dir.
  - start=1, steps==0 → FINISH with no shift.
- RUN:
  - stop=1 → IDLE, aborted=1 next cycle, out frozen; stop beats hold.
  - else hold=1 → no shift, remaining unchanged.
  - else shift once and decrement remaining; if remaining was 1 → FINISH.
- FINISH: done=1 for exactly this cycle, then IDLE. start ignored.
- start while busy or in FINISH: ignored, not queued.
- Forward step: out ← {out[WIDTH-2:0], ~out[WIDTH-1]}.
- Reverse step: out ← {~out[0], out[WIDTH-1:1]}, the exact inverse of forward.
- wrap: registered; high the cycle after any shift whose result is all-zero. May coincide with done.
- Legal codes: all-zero, or contiguous 1s from either end (0..01..1 / 1..10..0).

## Timing
- start sampled at edge N → busy high from N.
- First shift at edge N+1; with no hold, last shift at edge N+S.
- done high for one cycle after edge N+S. busy falls at the same edge. Back in IDLE after edge N+S+1.
- Start-to-done latency = S+1 cycles, plus one cycle per held cycle.
- steps==0: done high the cycle after the start edge.
- stop at edge M: aborted high for one cycle after M; IDLE at M+1.
- Earliest next start accepted: first IDLE cycle after done or aborted.
- Max run = 2^CNT_W−1 steps; remaining never underflows.

## Configuration
JSEQ_LOAD_EN:
- Defined:
  - Adds ports load (in, 1) and load_val (in, WIDTH), honoured in IDLE only.
  - Legal load_val → out ← load_val.
  - Illegal load_val → out ← 0 and err ← 1, sticky until rst.
  - load and start in the same IDLE cycle: load wins, start dropped.
  - load outside IDLE is ignored.
- Undefined: load ports absent; err tied 0; out only changes by stepping or reset.

## Test plan
- Reset: rst high 2 cycles mid-run (out=0011) → out=0000, busy=0, done=0, aborted=0, wrap=0, err=0.
- Forward run: start, steps=3, dir=0 from 0000 → out 0001, 0011, 0111 on successive edges; busy high 3 cycles; done pulse 4 cycles after start edge.
- Full cycle and reverse: steps=8, dir=0 from 0000 → out=0000, wrap and done pulse together. Then steps=1, dir=1 → out=1000, no wrap.
- Hold and stop: steps=4 with hold high 2 cycles after the first shift → done 7 cycles after start. A separate run stopped after 2 shifts → out=0011, aborted pulse, no done.
- Edge requests: steps=0 → done next cycle, out unchanged. start asserted while busy → ignored, no extra run.
- JSEQ_LOAD_EN:
  - load_val=0111 → out=0111, err=0.
  - load_val=0101 → out=0000, err=1, and err stays 1 until rst.
  - load with start in the same cycle → loaded value, no run.
